multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle successor to the single-cycle opcode decoder: a Moore state machine that sequences the shared-memory MIPS datapath through fetch, decode, execute, memory and write-back steps. It sits between the instruction register's opcode field and the datapath muxes and strobes. It adds loads/stores, branches, jump, an optional memory-ready handshake and a retired-instruction counter.

## Interface
Parameters:
- ALUOP_W, 3: ALUOp width, ≥3; codes zero-extended.
- CNT_W, 32: retired-instruction counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- OP  in  6  opcode from instruction register; stable outside FETCH
- MemReady  in  1  memory done; used only with MEM_HANDSHAKE_EN
- PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst, Lui  out  1 each  datapath strobes/selects
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- ALUOp  out  ALUOP_W  100 add, 101 or, 110 sub, 111 R-type funct
- IllegalOp  out  1  unsupported opcode seen in DECODE
- Retire  out  1  last cycle of an instruction
- RetiredCount  out  CNT_W  instructions retired
- State  out  4  current state, for debug

## Operation
- Opcodes: R 0x00, J 0x02, BEQ 0x04, BNE 0x05, ADDI 0x08, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B.
- States (encoding): FETCH 0, DECODE 1, MEMADDR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, JUMP 9, IMMEXEC 10, IMMWB 11.
- Outputs are pure decode of State; any output not listed for a state is 0.
  - FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=01, ALUOp=add.
  - DECODE: ALUSrcB=11, ALUOp=add.
  - MEMADDR: ALUSrcA, ALUSrcB=10, ALUOp=add.
  - MEMREAD: MemRead, IorD.
  - MEMWB: MemtoReg, RegWrite.
  - MEMWRITE: MemWrite, IorD.
  - EXECUTE: ALUSrcA, ALUOp=R-type.
  - ALUWB: RegDst, RegWrite.
  - IMMEXEC and IMMWB: ALUSrcA, ALUSrcB=10; ALUOp=add for ADDI, or for ORI/LUI; Lui=1 for LUI. IMMWB also asserts RegWrite.
  - BRANCH: ALUSrcA, ALUOp=sub, PCWriteCond, PCSource=01; BranchNE=1 when OP=BNE.
  - JUMP: PCWrite, PCSource=10.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADDR (LW/SW), EXECUTE (R), IMMEXEC (ADDI/ORI/LUI), BRANCH (BEQ/BNE), JUMP (J), FETCH (other).
  - MEMADDR→MEMREAD (LW) or MEMWRITE (SW).
  - MEMREAD→MEMWB.
  - EXECUTE→ALUWB.
  - IMMEXEC→IMMWB.
  - MEMWB, MEMWRITE, ALUWB, IMMWB, BRANCH, JUMP→FETCH.
- Illegal opcode: IllegalOp=1 for the DECODE cycle only. No Retire, no register or memory write, then FETCH.
- Retire=1 in MEMWB, MEMWRITE, ALUWB, IMMWB, BRANCH, JUMP.
- RetiredCount increments by 1 on each clock edge where Retire=1. It wraps from 2^CNT_W−1 to 0.

## Timing
- Reset: on the edge with reset=1, State←FETCH and RetiredCount←0. While reset is high, all outputs except State and RetiredCount are forced to 0. Reset mid-instruction abandons it with no Retire.
- Cycles per instruction without stalls: LW 5; R, ADDI, ORI, LUI, SW 4; BEQ, BNE, J 3; illegal 2.
- Outputs change only after clock edges (Moore); no combinational path from OP or MemReady to strobes, except the handshake gating below.

## Configuration
- MEM_HANDSHAKE_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold while MemReady=0.
  - IRWrite and PCWrite in FETCH are gated by MemReady. MemRead and MemWrite stay high throughout the wait.
  - MEMWRITE's Retire is gated by MemReady. The state advances on the edge where MemReady=1.
- Not defined: MemReady is ignored and each memory state lasts exactly one cycle.

## Test plan
- Reset held 3 cycles, then OP=0x00 → State 0,1,6,7,0; RegWrite=1 and RegDst=1 in cycle 4; RetiredCount=1.
- OP=0x23 (LW) → 5 cycles; MemRead and IorD in state 3; MemtoReg and RegWrite in state 4. OP=0x2B (SW) → MemWrite in state 5, 4 cycles.
- OP=0x05 → BRANCH with PCWriteCond=1, BranchNE=1, ALUOp=110, PCSource=01; 3 cycles. OP=0x02 → PCSource=10, PCWrite=1.
- OP=0x0F → IMMEXEC and IMMWB with Lui=1, ALUOp=101. OP=0x3F → IllegalOp pulse in DECODE, back to FETCH, RetiredCount unchanged.
- With MEM_HANDSHAKE_EN, MemReady=0 for 4 cycles during FETCH → State stays 0 with IRWrite=0, then advances the cycle after MemReady=1. Reset asserted in MEMREAD → FETCH next cycle, no Retire.
- CNT_W=4: run 17 instructions → RetiredCount wraps to 1.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM sequencing a shared-memory multicycle MIPS datapath.
// Optional memory-ready handshake enabled by defining MEM_HANDSHAKE_EN.
module multicycle_control #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OP,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNE,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               Lui,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               IllegalOp,
    output logic               Retire,
    output logic [CNT_W-1:0]   RetiredCount,
    output logic [3:0]         State
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b100);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b101);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b110);
    localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(3'b111);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMMEXEC  = 4'd10,
        S_IMMWB    = 4'd11
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_rdy;

`ifdef MEM_HANDSHAKE_EN
    assign mem_rdy = MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_rdy = 1'b1;
`endif

    logic is_legal;
    assign is_legal = (OP == OP_R)    || (OP == OP_J)   || (OP == OP_BEQ) ||
                      (OP == OP_BNE)  || (OP == OP_ADDI)|| (OP == OP_ORI) ||
                      (OP == OP_LUI)  || (OP == OP_LW)  || (OP == OP_SW);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (OP)
                    OP_LW, OP_SW:            state_d = S_MEMADDR;
                    OP_R:                    state_d = S_EXECUTE;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_IMMEXEC;
                    OP_BEQ, OP_BNE:          state_d = S_BRANCH;
                    OP_J:                    state_d = S_JUMP;
                    default:                 state_d = S_FETCH;
                endcase
            end
            S_MEMADDR:  state_d = (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_IMMEXEC:  state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP:
                        state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Strobes decode the registered state; OP only qualifies states entered
    // after the instruction register is loaded, so it is stable there.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        Lui         = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = '0;
        IllegalOp   = 1'b0;
        Retire      = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_rdy;
                PCWrite = mem_rdy;
                ALUSrcB = 2'b01;
                ALUOp   = ALU_ADD;
            end
            S_DECODE: begin
                ALUSrcB   = 2'b11;
                ALUOp     = ALU_ADD;
                IllegalOp = ~is_legal;
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_ADD;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                Retire   = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Retire   = mem_rdy;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_R;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                Retire   = 1'b1;
            end
            S_IMMEXEC, S_IMMWB: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                ALUOp    = (OP == OP_ADDI) ? ALU_ADD : ALU_OR;
                Lui      = (OP == OP_LUI);
                RegWrite = (state_q == S_IMMWB);
                Retire   = (state_q == S_IMMWB);
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNE    = (OP == OP_BNE);
                Retire      = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                Retire   = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            BranchNE    = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            ALUSrcA     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            Lui         = 1'b0;
            PCSource    = 2'b00;
            ALUSrcB     = 2'b00;
            ALUOp       = '0;
            IllegalOp   = 1'b0;
            Retire      = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(Retire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign State        = state_q;
    assign RetiredCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus
// hand sequences for memory waits, mid-instruction reset and counter wrap.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  OP;
    logic        MemReady;

    logic        PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, ALUSrcA, RegWrite, RegDst, Lui, IllegalOp, Retire;
    logic [1:0]  PCSource, ALUSrcB;
    logic [2:0]  ALUOp;
    logic [31:0] RetiredCount;
    logic [3:0]  State;

    logic        w_pcw, w_pcwc, w_bne, w_iord, w_mr, w_mw, w_irw;
    logic        w_m2r, w_asa, w_rw, w_rd, w_lui, w_ill, w_ret;
    logic [1:0]  w_pcs, w_asb;
    logic [2:0]  w_aop;
    logic [3:0]  w_cnt, w_st;

    always #5 clk = ~clk;

    multicycle_control #(.ALUOP_W(3), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .Lui(Lui), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .IllegalOp(IllegalOp), .Retire(Retire),
        .RetiredCount(RetiredCount), .State(State)
    );

    multicycle_control #(.ALUOP_W(3), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
        .PCWrite(w_pcw), .PCWriteCond(w_pcwc), .BranchNE(w_bne),
        .IorD(w_iord), .MemRead(w_mr), .MemWrite(w_mw), .IRWrite(w_irw),
        .MemtoReg(w_m2r), .ALUSrcA(w_asa), .RegWrite(w_rw),
        .RegDst(w_rd), .Lui(w_lui), .PCSource(w_pcs), .ALUSrcB(w_asb),
        .ALUOp(w_aop), .IllegalOp(w_ill), .Retire(w_ret),
        .RetiredCount(w_cnt), .State(w_st)
    );

    logic [20:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, ALUSrcA, RegWrite, RegDst, Lui, PCSource, ALUSrcB,
                   ALUOp, IllegalOp, Retire};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [20:0] c;
    } vec_t;

    vec_t        tbl[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 0;

    logic [20:0] C_FETCH, C_FETCH_W, C_DEC, C_DEC_ILL, C_MADDR, C_MREAD, C_MWB;
    logic [20:0] C_MWR, C_MWR_W, C_EXEC, C_ALUWB, C_BEQ, C_BNE, C_JUMP;
    logic [20:0] C_IEX_ADD, C_IEX_OR, C_IEX_LUI, C_IWB_ADD, C_IWB_OR, C_IWB_LUI;

    function automatic logic [20:0] ctl(
        input logic pcw, pcwc, bne, iord, mr, mw, irw, m2r, asa, rw, rd, lui,
        input logic [1:0] pcs, asb, input logic [2:0] aop, input logic ill, ret);
        return {pcw, pcwc, bne, iord, mr, mw, irw, m2r, asa, rw, rd, lui,
                pcs, asb, aop, ill, ret};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [5:0] op, input logic [3:0] st,
                       input logic [20:0] c);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = 1'b1; v.st = st; v.c = c;
        tbl.push_back(v);
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance the count model.
    task automatic run_vec(input string tag, input vec_t v);
        @(negedge clk);
        reset = v.rst; OP = v.op; MemReady = v.rdy;
        #1;
        chk({tag, " state"}, 32'(State), 32'(v.st));
        chk({tag, " ctrl"}, 32'(ctrl), 32'(v.c));
        chk({tag, " count"}, RetiredCount, exp_cnt);
        if (v.rst) exp_cnt = 0;
        else if (v.c[0]) exp_cnt = exp_cnt + 1;
    endtask

    task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                       input logic rdy, input logic [3:0] st, input logic [20:0] c);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.c = c;
        run_vec(tag, v);
    endtask

    initial begin
        C_FETCH   = ctl(1,0,0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b01, 3'b100, 0, 0);
        C_FETCH_W = ctl(0,0,0,0,1,0,0,0,0,0,0,0, 2'b00, 2'b01, 3'b100, 0, 0);
        C_DEC     = ctl(0,0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 3'b100, 0, 0);
        C_DEC_ILL = ctl(0,0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 3'b100, 1, 0);
        C_MADDR   = ctl(0,0,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b10, 3'b100, 0, 0);
        C_MREAD   = ctl(0,0,0,1,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 0);
        C_MWB     = ctl(0,0,0,0,0,0,0,1,0,1,0,0, 2'b00, 2'b00, 3'b000, 0, 1);
        C_MWR     = ctl(0,0,0,1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 1);
        C_MWR_W   = ctl(0,0,0,1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 0);
        C_EXEC    = ctl(0,0,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b111, 0, 0);
        C_ALUWB   = ctl(0,0,0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b000, 0, 1);
        C_BEQ     = ctl(0,1,0,0,0,0,0,0,1,0,0,0, 2'b01, 2'b00, 3'b110, 0, 1);
        C_BNE     = ctl(0,1,1,0,0,0,0,0,1,0,0,0, 2'b01, 2'b00, 3'b110, 0, 1);
        C_JUMP    = ctl(1,0,0,0,0,0,0,0,0,0,0,0, 2'b10, 2'b00, 3'b000, 0, 1);
        C_IEX_ADD = ctl(0,0,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b10, 3'b100, 0, 0);
        C_IEX_OR  = ctl(0,0,0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b10, 3'b101, 0, 0);
        C_IEX_LUI = ctl(0,0,0,0,0,0,0,0,1,0,0,1, 2'b00, 2'b10, 3'b101, 0, 0);
        C_IWB_ADD = ctl(0,0,0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b10, 3'b100, 0, 1);
        C_IWB_OR  = ctl(0,0,0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b10, 3'b101, 0, 1);
        C_IWB_LUI = ctl(0,0,0,0,0,0,0,0,1,1,0,1, 2'b00, 2'b10, 3'b101, 0, 1);

        add(1, 6'h00, 4'd0, 21'd0);
        add(1, 6'h00, 4'd0, 21'd0);
        add(0, 6'h00, 4'd0, C_FETCH);  add(0, 6'h00, 4'd1, C_DEC);
        add(0, 6'h00, 4'd6, C_EXEC);   add(0, 6'h00, 4'd7, C_ALUWB);
        add(0, 6'h23, 4'd0, C_FETCH);  add(0, 6'h23, 4'd1, C_DEC);
        add(0, 6'h23, 4'd2, C_MADDR);  add(0, 6'h23, 4'd3, C_MREAD);
        add(0, 6'h23, 4'd4, C_MWB);
        add(0, 6'h2B, 4'd0, C_FETCH);  add(0, 6'h2B, 4'd1, C_DEC);
        add(0, 6'h2B, 4'd2, C_MADDR);  add(0, 6'h2B, 4'd5, C_MWR);
        add(0, 6'h05, 4'd0, C_FETCH);  add(0, 6'h05, 4'd1, C_DEC);
        add(0, 6'h05, 4'd8, C_BNE);
        add(0, 6'h04, 4'd0, C_FETCH);  add(0, 6'h04, 4'd1, C_DEC);
        add(0, 6'h04, 4'd8, C_BEQ);
        add(0, 6'h02, 4'd0, C_FETCH);  add(0, 6'h02, 4'd1, C_DEC);
        add(0, 6'h02, 4'd9, C_JUMP);
        add(0, 6'h0F, 4'd0, C_FETCH);  add(0, 6'h0F, 4'd1, C_DEC);
        add(0, 6'h0F, 4'd10, C_IEX_LUI); add(0, 6'h0F, 4'd11, C_IWB_LUI);
        add(0, 6'h08, 4'd0, C_FETCH);  add(0, 6'h08, 4'd1, C_DEC);
        add(0, 6'h08, 4'd10, C_IEX_ADD); add(0, 6'h08, 4'd11, C_IWB_ADD);
        add(0, 6'h0D, 4'd0, C_FETCH);  add(0, 6'h0D, 4'd1, C_DEC);
        add(0, 6'h0D, 4'd10, C_IEX_OR);  add(0, 6'h0D, 4'd11, C_IWB_OR);
        add(0, 6'h3F, 4'd0, C_FETCH);  add(0, 6'h3F, 4'd1, C_DEC_ILL);
        add(0, 6'h00, 4'd0, C_FETCH);  add(0, 6'h00, 4'd1, C_DEC);
        add(1, 6'h00, 4'd6, 21'd0);
        add(0, 6'h00, 4'd0, C_FETCH);

        reset = 1'b1; OP = 6'h00; MemReady = 1'b1;
        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++)
            run_vec($sformatf("row%0d", i), tbl[i]);
        chk("count4 vs model", 32'(w_cnt), 32'(exp_cnt[3:0]));

`ifdef MEM_HANDSHAKE_EN
        // Finish the R left in DECODE, then a stalled LW fetch and memory read.
        cyc("hs dec", 0, 6'h00, 1, 4'd1, C_DEC);
        cyc("hs exe", 0, 6'h00, 1, 4'd6, C_EXEC);
        cyc("hs wb", 0, 6'h00, 1, 4'd7, C_ALUWB);
        for (int i = 0; i < 4; i++)
            cyc($sformatf("hs fwait%0d", i), 0, 6'h23, 0, 4'd0, C_FETCH_W);
        cyc("hs fgo", 0, 6'h23, 1, 4'd0, C_FETCH);
        cyc("hs dec2", 0, 6'h23, 0, 4'd1, C_DEC);
        cyc("hs maddr", 0, 6'h23, 0, 4'd2, C_MADDR);
        cyc("hs rwait", 0, 6'h23, 0, 4'd3, C_MREAD);
        cyc("hs rgo", 0, 6'h23, 1, 4'd3, C_MREAD);
        cyc("hs mwb", 0, 6'h23, 1, 4'd4, C_MWB);
        cyc("hs sw f", 0, 6'h2B, 1, 4'd0, C_FETCH);
        cyc("hs sw d", 0, 6'h2B, 1, 4'd1, C_DEC);
        cyc("hs sw a", 0, 6'h2B, 1, 4'd2, C_MADDR);
        cyc("hs wwait", 0, 6'h2B, 0, 4'd5, C_MWR_W);
        cyc("hs wwait2", 0, 6'h2B, 0, 4'd5, C_MWR_W);
        cyc("hs wgo", 0, 6'h2B, 1, 4'd5, C_MWR);
        cyc("hs back", 0, 6'h23, 1, 4'd0, C_FETCH);
`else
        // MemReady is ignored: LW still takes exactly 5 cycles with it low.
        cyc("nr dec", 0, 6'h00, 0, 4'd1, C_DEC);
        cyc("nr exe", 0, 6'h00, 0, 4'd6, C_EXEC);
        cyc("nr wb", 0, 6'h00, 0, 4'd7, C_ALUWB);
        cyc("nr f", 0, 6'h23, 0, 4'd0, C_FETCH);
        cyc("nr d", 0, 6'h23, 0, 4'd1, C_DEC);
        cyc("nr a", 0, 6'h23, 0, 4'd2, C_MADDR);
        cyc("nr r", 0, 6'h23, 0, 4'd3, C_MREAD);
        cyc("nr wb2", 0, 6'h23, 0, 4'd4, C_MWB);
        cyc("nr back", 0, 6'h23, 1, 4'd0, C_FETCH);
`endif
        // Reset asserted while in MEMREAD abandons the load.
        cyc("rr d", 0, 6'h23, 1, 4'd1, C_DEC);
        cyc("rr a", 0, 6'h23, 1, 4'd2, C_MADDR);
        cyc("rr rst", 1, 6'h23, 1, 4'd3, 21'd0);
        cyc("rr fetch", 0, 6'h00, 1, 4'd0, C_FETCH);

        // 17 R-type instructions wrap the 4-bit counter to 1.
        cyc("wrap d", 0, 6'h00, 1, 4'd1, C_DEC);
        cyc("wrap e", 0, 6'h00, 1, 4'd6, C_EXEC);
        cyc("wrap w", 0, 6'h00, 1, 4'd7, C_ALUWB);
        for (int i = 1; i < 17; i++) begin
            cyc("wrap f", 0, 6'h00, 1, 4'd0, C_FETCH);
            cyc("wrap d", 0, 6'h00, 1, 4'd1, C_DEC);
            cyc("wrap e", 0, 6'h00, 1, 4'd6, C_EXEC);
            cyc("wrap w", 0, 6'h00, 1, 4'd7, C_ALUWB);
        end
        @(negedge clk);
        #1;
        chk("wrap count32", RetiredCount, 32'd17);
        chk("wrap count4", 32'(w_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
